seq_scan_mux: RTL and testbench
===============================

SEQ_SCAN_MUX -- requirements
Module: seq_scan_mux

Interface
REQ-001: Parameter SELW, default 4, select width; channel count NCH = 2**SELW.
REQ-002: Parameter W, default 4, data width per channel.
REQ-003: clk  input  1  sole clock; all state updates on rising edge.
REQ-004: rst_n  input  1  reset, asynchronous, active-low.
REQ-005: in  input  NCH*W  packed channels; channel i = in[i*W +: W].
REQ-006: sel  input  SELW  channel index for single-shot mode.
REQ-007: mode  input  1  0 = single-shot, 1 = scan; sampled only with accepted start.
REQ-008: en_mask  input  NCH  scan channel enables, bit i = channel i; sampled only with accepted start.
REQ-009: start  input  1  request; accepted only in IDLE.
REQ-010: out_ready  input  1  downstream ready.
REQ-011: out_data  output  W  registered selected channel data.
REQ-012: out_ch  output  SELW  registered index of channel in out_data.
REQ-013: out_valid  output  1  out_data/out_ch valid.
REQ-014: busy  output  1  high whenever state is not IDLE.
REQ-015: done  output  1  one-cycle pulse at end of operation.

Function
REQ-016: States IDLE, SINGLE, SCAN; busy = (state != IDLE), combinational from state register.
REQ-017: Handshake = out_valid & out_ready at a rising edge; out_data, out_ch, out_valid SHALL stay stable while out_valid & !out_ready.
REQ-018: IDLE, start=1, mode=0: same edge capture in[sel], out_ch<=sel, out_valid<=1, go SINGLE; latency 1 edge.
REQ-019: IDLE, start=1, mode=1, en_mask!=0: latch en_mask internally, capture lowest enabled channel, out_valid<=1, go SCAN.
REQ-020: IDLE, start=1, mode=1, en_mask==0: no output, out_valid stays 0, done pulses next cycle, remain IDLE.
REQ-021: SINGLE, handshake: out_valid<=0, done<=1 for one cycle, go IDLE.
REQ-022: SCAN, handshake: if an enabled channel exists with index > out_ch, capture the lowest such (in[] sampled at that edge), out_valid stays 1 (back-to-back, zero bubble); else out_valid<=0, done<=1, go IDLE.
REQ-023: Data sampled at capture edge only; in changes after capture SHALL NOT alter out_data.
REQ-024: start while busy SHALL be ignored with no effect; sel, mode, en_mask changes while busy SHALL have no effect (latched copy used).
REQ-025: done and a new start in the same IDLE cycle: start accepted normally; done pulse is unaffected.
REQ-026: Channel index NCH-1 is terminal in scan; no wrap-around to channel 0.
REQ-027: All outputs registered except busy; no combinational path from in to out_data.

Reset
REQ-028: rst_n low SHALL asynchronously force state=IDLE, out_data=0, out_ch=0, out_valid=0, done=0, latched mask=0, independent of clk.
REQ-029: Reset mid-operation SHALL abort without done pulse; first start after rst_n rises is accepted on the first rising edge with rst_n high.

Verification (SELW=4, W=4, in=64'hFEDC_BA98_7654_3210, so channel i holds value i)
REQ-030: Single: start, mode=0, sel=6, out_ready=1 -> next edge out_data=4'h6, out_ch=6, out_valid=1; following edge out_valid=0, done=1 for one cycle.
REQ-031: Full scan: mode=1, en_mask=16'hFFFF, out_ready=1 -> out_data 0,1,...,F on 16 consecutive cycles, done after channel F, busy high for 16 cycles.
REQ-032: Sparse scan with backpressure: en_mask=16'h8421, out_ready toggling 1/0 -> only channels 0,5,A,F delivered in order, each held stable while out_ready=0, exactly one done.
REQ-033: Empty mask: mode=1, en_mask=0 -> out_valid never asserts, done pulses once, busy stays 0.
REQ-034: Reset abort: rst_n low mid-scan at channel 3 -> out_valid=0, out_data=0, busy=0 immediately, no done; new start afterwards operates normally.
REQ-035: Ignored start: second start with sel=1 during SINGLE on sel=9 held by out_ready=0 -> out_data stays 4'h9, one done total.

Source files
------------

// File: rtl/seq_scan_mux_if.sv
// Request/response bundle for seq_scan_mux: packed channel inputs, operation
// controls, and the registered output handshake.
interface seq_scan_mux_if #(
    parameter int SELW = 4,
    parameter int W    = 4
);
    localparam int NCH = 2 ** SELW;

    logic [NCH*W-1:0] in;
    logic [SELW-1:0]  sel;
    logic             mode;
    logic [NCH-1:0]   en_mask;
    logic             start;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [SELW-1:0]  out_ch;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output in, sel, mode, en_mask, start, out_ready,
        input  out_data, out_ch, out_valid, busy, done
    );

    modport slave (
        input  in, sel, mode, en_mask, start, out_ready,
        output out_data, out_ch, out_valid, busy, done
    );
endinterface

// File: rtl/seq_scan_mux.sv
// Channel multiplexer with single-shot select and ascending masked scan,
// presenting each captured channel on a registered valid/ready output.
module seq_scan_mux #(
    parameter int SELW = 4,
    parameter int W    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_scan_mux_if.slave bus
);
    localparam int NCH = 2 ** SELW;

    typedef enum logic [1:0] {IDLE, SINGLE, SCAN} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    data_q, data_nx;
    logic [SELW-1:0] ch_q, ch_nx;
    logic            valid_q, valid_nx;
    logic            done_q, done_nx;
    logic [NCH-1:0]  mask_q, mask_nx;

    logic [W-1:0]    chan [NCH];
    logic [NCH-1:0]  srch_mask;
    int              srch_lo;
    logic            hit;
    logic [SELW-1:0] hit_ch;
    logic            hs;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        assign chan[g] = bus.in[g*W +: W];
    end

    // Lowest set bit of m at index >= lo; lo == NCH means nothing is left.
    function automatic void find_next(input logic [NCH-1:0] m, input int lo,
                                      output logic found, output logic [SELW-1:0] idx);
        found = 1'b0;
        idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i] && i >= lo) begin
                found = 1'b1;
                idx   = i[SELW-1:0];
            end
        end
    endfunction

    // In IDLE the search looks at the incoming mask from channel 0; in SCAN it
    // resumes from the latched mask just above the channel being presented.
    always_comb begin
        srch_mask = (state == SCAN) ? mask_q : bus.en_mask;
        srch_lo   = (state == SCAN) ? int'(ch_q) + 1 : 0;
        find_next(srch_mask, srch_lo, hit, hit_ch);
    end

    assign hs = valid_q & bus.out_ready;

    always_comb begin
        state_nx = state;
        data_nx  = data_q;
        ch_nx    = ch_q;
        valid_nx = valid_q;
        done_nx  = 1'b0;
        mask_nx  = mask_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (!bus.mode) begin
                        data_nx  = chan[bus.sel];
                        ch_nx    = bus.sel;
                        valid_nx = 1'b1;
                        state_nx = SINGLE;
                    end else if (hit) begin
                        mask_nx  = bus.en_mask;
                        data_nx  = chan[hit_ch];
                        ch_nx    = hit_ch;
                        valid_nx = 1'b1;
                        state_nx = SCAN;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            SINGLE: begin
                if (hs) begin
                    valid_nx = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            SCAN: begin
                if (hs) begin
                    if (hit) begin
                        data_nx = chan[hit_ch];
                        ch_nx   = hit_ch;
                    end else begin
                        valid_nx = 1'b0;
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            mask_q  <= '0;
        end else begin
            state   <= state_nx;
            data_q  <= data_nx;
            ch_q    <= ch_nx;
            valid_q <= valid_nx;
            done_q  <= done_nx;
            mask_q  <= mask_nx;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
    assign bus.out_valid = valid_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_seq_scan_mux.sv
// Directed bench for seq_scan_mux: a vector table for single/empty/sparse
// operations plus hand-written full-scan, capture-hold and reset-abort runs.
module tb_seq_scan_mux;
    localparam logic [63:0] IN_ID = 64'hFEDC_BA98_7654_3210;

    logic clk = 1'b0;
    logic rst_n;

    seq_scan_mux_if #(.SELW(4), .W(4)) bus_if ();

    seq_scan_mux #(.SELW(4), .W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        start;
        logic        mode;
        logic [3:0]  sel;
        logic [15:0] mask;
        logic        rdy;
        logic        e_valid;
        logic [3:0]  e_data;
        logic [3:0]  e_ch;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t vecs [16];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic md, input logic [3:0] sl,
                         input logic [15:0] mk, input logic rd);
        bus_if.start     = st;
        bus_if.mode      = md;
        bus_if.sel       = sl;
        bus_if.en_mask   = mk;
        bus_if.out_ready = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 4'd6, 16'h0000, 1'b1, 1'b1, 4'h6, 4'd6,  1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 4'h0, 4'd0,  1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 4'h0, 4'd0,  1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 4'd0, 16'h0000, 1'b1, 1'b0, 4'h0, 4'd0,  1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 4'h0, 4'd0,  1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 4'd0, 16'h8421, 1'b0, 1'b1, 4'h0, 4'd0,  1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 4'h5, 4'd5,  1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 4'd1, 16'h0000, 1'b0, 1'b1, 4'h5, 4'd5,  1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b1, 1'b1, 4'hA, 4'd10, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 4'hA, 4'd10, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 4'hF, 4'd15, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 4'hF, 4'd15, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 4'h0, 4'd0,  1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 4'd2, 16'h0000, 1'b0, 1'b1, 4'h2, 4'd2,  1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 4'h0, 4'd0,  1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'd0,  1'b0, 1'b0};

        bus_if.in = IN_ID;
        drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_data",  32'(bus_if.out_data),  32'd0);
        check("rst_ch",    32'(bus_if.out_ch),    32'd0);
        check("rst_busy",  32'(bus_if.busy),      32'd0);
        check("rst_done",  32'(bus_if.done),      32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].start, vecs[i].mode, vecs[i].sel, vecs[i].mask, vecs[i].rdy);
            tick();
            check($sformatf("vec%0d_valid", i), 32'(bus_if.out_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d_busy", i),  32'(bus_if.busy),      32'(vecs[i].e_busy));
            check($sformatf("vec%0d_done", i),  32'(bus_if.done),      32'(vecs[i].e_done));
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_data", i), 32'(bus_if.out_data), 32'(vecs[i].e_data));
                check($sformatf("vec%0d_ch", i),   32'(bus_if.out_ch),   32'(vecs[i].e_ch));
            end
        end

        // Full scan with ready held high: one channel per cycle, no bubbles.
        drive(1'b1, 1'b1, 4'd0, 16'hFFFF, 1'b1);
        tick();
        drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("scan%0d_valid", k), 32'(bus_if.out_valid), 32'd1);
            check($sformatf("scan%0d_data", k),  32'(bus_if.out_data),  32'(k));
            check($sformatf("scan%0d_ch", k),    32'(bus_if.out_ch),    32'(k));
            check($sformatf("scan%0d_busy", k),  32'(bus_if.busy),      32'd1);
            check($sformatf("scan%0d_done", k),  32'(bus_if.done),      32'd0);
            tick();
        end
        check("scan_end_valid", 32'(bus_if.out_valid), 32'd0);
        check("scan_end_busy",  32'(bus_if.busy),      32'd0);
        check("scan_end_done",  32'(bus_if.done),      32'd1);
        tick();
        check("scan_post_done", 32'(bus_if.done), 32'd0);

        // Single on channel 9 held by backpressure; a second start and input churn must not disturb it.
        drive(1'b1, 1'b0, 4'd9, 16'h0000, 1'b0);
        tick();
        check("hold_data0", 32'(bus_if.out_data), 32'h9);
        drive(1'b1, 1'b0, 4'd1, 16'h0000, 1'b0);
        bus_if.in = ~IN_ID;
        tick();
        check("hold_data1", 32'(bus_if.out_data),  32'h9);
        check("hold_ch1",   32'(bus_if.out_ch),    32'd9);
        check("hold_valid", 32'(bus_if.out_valid), 32'd1);
        check("hold_done1", 32'(bus_if.done),      32'd0);
        drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
        bus_if.in = IN_ID;
        tick();
        check("hold_end_valid", 32'(bus_if.out_valid), 32'd0);
        check("hold_end_done",  32'(bus_if.done),      32'd1);
        tick();
        check("hold_post_done", 32'(bus_if.done), 32'd0);
        check("hold_post_busy", 32'(bus_if.busy), 32'd0);

        // Reset asserted mid-scan while channel 3 is presented.
        drive(1'b1, 1'b1, 4'd0, 16'hFFFF, 1'b1);
        tick();
        drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
        tick();
        tick();
        tick();
        check("abort_pre_ch", 32'(bus_if.out_ch), 32'd3);
        bus_if.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(bus_if.out_valid), 32'd0);
        check("abort_data",  32'(bus_if.out_data),  32'd0);
        check("abort_busy",  32'(bus_if.busy),      32'd0);
        check("abort_done",  32'(bus_if.done),      32'd0);
        tick();
        #2 rst_n = 1'b1;
        check("abort_done_after", 32'(bus_if.done), 32'd0);
        drive(1'b1, 1'b0, 4'd6, 16'h0000, 1'b1);
        tick();
        drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
        check("after_rst_valid", 32'(bus_if.out_valid), 32'd1);
        check("after_rst_data",  32'(bus_if.out_data),  32'h6);
        check("after_rst_ch",    32'(bus_if.out_ch),    32'd6);
        tick();
        check("after_rst_done",  32'(bus_if.done),      32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
